// File: rtl/instruction_fetcher_pkg.sv
// Shared core definitions for the instruction fetcher.
//   - SIMD core state encoding (driven by the core sequencer)
//   - Fetcher FSM state encoding (reported on fetcher_state)
package instruction_fetcher_pkg;

   localparam int SIMD_STATE_W    = 3;
   localparam int FETCHER_STATE_W = 2;

   typedef enum logic [SIMD_STATE_W-1:0] {
      SIMD_IDLE    = 3'd0,
      SIMD_FETCH   = 3'd1,
      SIMD_DECODE  = 3'd2,
      SIMD_REQUEST = 3'd3,
      SIMD_WAIT    = 3'd4,
      SIMD_EXECUTE = 3'd5,
      SIMD_UPDATE  = 3'd6,
      SIMD_DONE    = 3'd7
   } simd_state_e;

   // Code 3 is unused; the FSM returns to F_IDLE from it.
   typedef enum logic [FETCHER_STATE_W-1:0] {
      F_IDLE     = 2'd0,
      F_FETCHING = 2'd1,
      F_FETCHED  = 2'd2
   } fetcher_state_e;

endpackage

// File: rtl/instruction_fetcher_if.sv
// Program-memory read bus between the fetcher (master) and program memory
// (slave).
//   mem_read_valid    master->slave  read request, held until ready
//   mem_read_address  master->slave  word address, held with valid
//   mem_read_ready    slave->master  response valid this cycle
//   mem_read_data     slave->master  returned instruction word
interface instruction_fetcher_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              mem_read_valid;
   logic [ADDR_W-1:0] mem_read_address;
   logic              mem_read_ready;
   logic [DATA_W-1:0] mem_read_data;

   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher with a one-entry last-fetch holding register.
// A fetch for the same pc as the previous completed fetch is served from the
// holding register in one cycle (fetch_hit pulse); otherwise program memory
// is read over the mem bus.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          core enable; 0 freezes every register
//   simd_state      core sequencer state (SIMD_FETCH starts, SIMD_DECODE releases)
//   pc              address of next instruction, sampled at the fetch decision
//   flush           invalidates the holding register
//   mem             program-memory read bus (master side)
//   instruction     fetched word for the decoder
//   fetcher_state   current FSM state
//   fetch_hit       one-cycle pulse after a hit decision
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH  = 32,
   parameter int PROGRAM_ADDR_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [SIMD_STATE_W-1:0]       simd_state,
   input  logic [PROGRAM_ADDR_WIDTH-1:0] pc,
   input  logic                          flush,
   instruction_fetcher_if.master         mem,
   output logic [INSTRUCTION_WIDTH-1:0]  instruction,
   output logic [FETCHER_STATE_W-1:0]    fetcher_state,
   output logic                          fetch_hit
);

   fetcher_state_e                state_q, state_n;
   logic                          valid_q, valid_n;
   logic [PROGRAM_ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [INSTRUCTION_WIDTH-1:0]  instr_q, instr_n;
   logic                          hit_q, hit_n;

   // Holding register: last completed memory fetch.
   logic                          last_valid_q, last_valid_n;
   logic [PROGRAM_ADDR_WIDTH-1:0] last_pc_q, last_pc_n;
   logic [INSTRUCTION_WIDTH-1:0]  last_word_q, last_word_n;

   logic hit;

   // Flush takes priority over a coincident hit check.
   assign hit = last_valid_q && (last_pc_q == pc) && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= F_IDLE;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         instr_q      <= '0;
         hit_q        <= 1'b0;
         last_valid_q <= 1'b0;
         last_pc_q    <= '0;
         last_word_q  <= '0;
      end else if (enable) begin
         state_q      <= state_n;
         valid_q      <= valid_n;
         addr_q       <= addr_n;
         instr_q      <= instr_n;
         hit_q        <= hit_n;
         last_valid_q <= last_valid_n;
         last_pc_q    <= last_pc_n;
         last_word_q  <= last_word_n;
      end
   end

   always_comb begin
      state_n      = state_q;
      valid_n      = valid_q;
      addr_n       = addr_q;
      instr_n      = instr_q;
      hit_n        = 1'b0;
      last_valid_n = last_valid_q && !flush;
      last_pc_n    = last_pc_q;
      last_word_n  = last_word_q;

      case (state_q)
         F_IDLE: begin
            if (simd_state == SIMD_FETCH) begin
               if (hit) begin
                  instr_n = last_word_q;
                  hit_n   = 1'b1;
                  state_n = F_FETCHED;
               end else begin
                  valid_n = 1'b1;
                  addr_n  = pc;
                  state_n = F_FETCHING;
               end
            end
         end
         // Only ready ends the request; simd_state is not consulted here.
         // A response arriving after a flush is fresh, so it revalidates.
         F_FETCHING: begin
            if (mem.mem_read_ready) begin
               instr_n      = mem.mem_read_data;
               last_word_n  = mem.mem_read_data;
               last_pc_n    = addr_q;
               last_valid_n = 1'b1;
               valid_n      = 1'b0;
               state_n      = F_FETCHED;
            end
         end
         F_FETCHED: begin
            if (simd_state == SIMD_DECODE)
               state_n = F_IDLE;
         end
         default: begin
            state_n = F_IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   assign mem.mem_read_valid   = valid_q;
   assign mem.mem_read_address = addr_q;
   assign instruction          = instr_q;
   assign fetcher_state        = state_q;
   assign fetch_hit            = hit_q;

endmodule
